// File: rtl/enc_snapshot_pkg.sv
`default_nettype none
// ============================================================================
// enc_snapshot_pkg : encoder register map constants and snapshot FSM encoding
// Revision: 1.0
// ============================================================================
package enc_snapshot_pkg;

    localparam logic [3:0] ADDR_MAIN     = 4'h0;
    localparam logic [3:0] OFF_ENC_DATA  = 4'h2;
    localparam logic [3:0] OFF_PER_DATA  = 4'h3;
    localparam logic [3:0] OFF_FREQ_DATA = 4'h4;
    localparam logic [3:0] OFF_SNAP_TS   = 4'd12;
    localparam logic [3:0] OFF_SNAP_STAT = 4'd15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SWAP = 2'd2;

    // Register offset of the word-in-channel slot: quad, period, freq.
    function automatic logic [3:0] word_off(input logic [1:0] sel);
        case (sel)
            2'd0:    word_off = OFF_ENC_DATA;
            2'd1:    word_off = OFF_PER_DATA;
            default: word_off = OFF_FREQ_DATA;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_snapshot_if.sv
`default_nettype none
// ============================================================================
// enc_snapshot_if : snapshot control, encoder read port and host read port
// Revision: 1.0
// ============================================================================
interface enc_snapshot_if;
    logic        snap_req;
    logic        clr_overrun;
    logic [15:0] enc_raddr;
    logic [31:0] enc_rdata;
    logic [3:0]  buf_raddr;
    logic [31:0] buf_rdata;
    logic        snap_busy;
    logic        snap_done;
    logic [7:0]  snap_seq;
    logic        overrun;

    modport slave (
        input  snap_req, clr_overrun, enc_rdata, buf_raddr,
        output enc_raddr, buf_rdata, snap_busy, snap_done, snap_seq, overrun
    );

    modport master (
        output snap_req, clr_overrun, enc_rdata, buf_raddr,
        input  enc_raddr, buf_rdata, snap_busy, snap_done, snap_seq, overrun
    );
endinterface
`default_nettype wire

// File: rtl/enc_snapshot_bank.sv
`default_nettype none
// ============================================================================
// enc_snapshot_bank : 16x32 register array, one write port, registered read
// Revision: 1.0
// ============================================================================
module enc_snapshot_bank (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] mem_q [16];
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 32'h0;
            end
            rdata_q <= 32'h0;
        end else begin
            if (we) begin
                mem_q[waddr] <= wdata;
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule
`default_nettype wire

// File: rtl/enc_snapshot.sv
`default_nettype none
// ============================================================================
// enc_snapshot : double-buffered coherent capture of all encoder channels
// Revision: 1.0
// ============================================================================
module enc_snapshot
    import enc_snapshot_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WPC    = 3
) (
    input  logic          sysclk,
    input  logic          reset,
    enc_snapshot_if.slave bus
);
    localparam int         NWORDS   = NUM_CH * WPC;
    localparam logic [3:0] IDX_LAST = 4'(NWORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] tick_q, tick_d;
    logic [31:0] ts_q, ts_d;
    logic        active_q, active_d;
    logic [7:0]  seq_q, seq_d;
    logic        ovr_q, ovr_d;
    logic        sel_q, sel_d;
    logic        is_stat_q, is_stat_d;
    logic [31:0] stat_q, stat_d;

    logic        busy;
    logic [3:0]  ch;
    logic [3:0]  off;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] bank_rdata [2];

    assign busy = (state_q != ST_IDLE);
    assign ch   = 4'(int'(idx_q) / WPC + 1);
    assign off  = word_off(2'(int'(idx_q) % WPC));

    // Captures always land in the bank the host is not reading.
    assign wr_en   = (state_q == ST_RUN) || (state_q == ST_SWAP);
    assign wr_addr = (state_q == ST_SWAP) ? OFF_SNAP_TS : idx_q;
    assign wr_data = (state_q == ST_SWAP) ? ts_q : bus.enc_rdata;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        enc_snapshot_bank u_bank (
            .sysclk (sysclk),
            .reset  (reset),
            .we     (wr_en && (active_q != 1'(b))),
            .waddr  (wr_addr),
            .wdata  (wr_data),
            .raddr  (bus.buf_raddr),
            .rdata  (bank_rdata[b])
        );
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ts_d      = ts_q;
        active_d  = active_q;
        seq_d     = seq_q;
        tick_d    = tick_q + 32'd1;
        sel_d     = active_q;
        is_stat_d = (bus.buf_raddr == OFF_SNAP_STAT);
        stat_d    = {seq_q, 22'd0, busy, ovr_q};

        case (state_q)
            ST_IDLE: begin
                idx_d = 4'd0;
                ts_d  = tick_q;
                if (bus.snap_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                active_d = ~active_q;
                seq_d    = seq_q + 8'd1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A request that cannot be taken is lost; setting beats clearing.
        if (bus.snap_req && busy) begin
            ovr_d = 1'b1;
        end else if (bus.clr_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            tick_q    <= 32'd0;
            ts_q      <= 32'd0;
            active_q  <= 1'b0;
            seq_q     <= 8'd0;
            ovr_q     <= 1'b0;
            sel_q     <= 1'b0;
            is_stat_q <= 1'b0;
            stat_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tick_q    <= tick_d;
            ts_q      <= ts_d;
            active_q  <= active_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
            sel_q     <= sel_d;
            is_stat_q <= is_stat_d;
            stat_q    <= stat_d;
        end
    end

    assign bus.enc_raddr = (state_q == ST_RUN) ? {ADDR_MAIN, 4'h0, ch, off} : 16'h0000;
    assign bus.buf_rdata = is_stat_q ? stat_q : bank_rdata[sel_q];
    assign bus.snap_busy = busy;
    assign bus.snap_done = (state_q == ST_SWAP);
    assign bus.snap_seq  = seq_q;
    assign bus.overrun   = ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_enc_snapshot.sv
`default_nettype none
// ============================================================================
// tb_enc_snapshot : directed and randomized checks against a snapshot model
// Revision: 1.0
// ============================================================================
module tb_enc_snapshot;
    import enc_snapshot_pkg::*;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] epoch  = 8'h11;
    int         n_chk  = 0;
    int         n_fail = 0;

    enc_snapshot_if bus();

    enc_snapshot #(.NUM_CH(4), .WPC(3)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    // Upstream register file: word tags epoch and address; quad is 25 bits.
    function automatic logic [31:0] updata(input logic [15:0] a, input logic [7:0] ep);
        logic [31:0] d;
        d = {ep, 8'hA5, a};
        if (a[3:0] == OFF_ENC_DATA) d = d & 32'h01FF_FFFF;
        return d;
    endfunction

    function automatic logic [3:0] off_of(input int k);
        if (k == 0) return OFF_ENC_DATA;
        if (k == 1) return OFF_PER_DATA;
        return OFF_FREQ_DATA;
    endfunction

    function automatic logic [15:0] exp_addr(input int i);
        return 16'((i / 3 + 1) * 16) | {12'h0, off_of(i % 3)};
    endfunction

    assign bus.enc_rdata = updata(bus.enc_raddr, epoch);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Snapshot model: phase 0 idle, 1..12 word captures, 13 the swap cycle.
    logic [31:0] m_cyc, m_ts, m_rd;
    int          m_phase;
    logic [7:0]  m_seq;
    logic        m_ovr;
    logic [31:0] m_vis  [16];
    logic [31:0] m_pend [12];

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_cyc   <= 32'd0;
            m_ts    <= 32'd0;
            m_rd    <= 32'd0;
            m_phase <= 0;
            m_seq   <= 8'd0;
            m_ovr   <= 1'b0;
            for (int i = 0; i < 16; i++) m_vis[i] <= 32'd0;
        end else begin
            m_cyc <= m_cyc + 32'd1;
            if (bus.buf_raddr == 4'd15)
                m_rd <= {m_seq, 22'd0, (m_phase != 0), m_ovr};
            else
                m_rd <= m_vis[bus.buf_raddr];
            if (bus.snap_req && m_phase != 0) m_ovr <= 1'b1;
            else if (bus.clr_overrun)         m_ovr <= 1'b0;
            if (m_phase == 0) begin
                if (bus.snap_req) begin
                    m_phase <= 1;
                    m_ts    <= m_cyc;
                end
            end else if (m_phase <= 12) begin
                m_pend[m_phase-1] <= updata(exp_addr(m_phase - 1), epoch);
                m_phase <= m_phase + 1;
            end else begin
                for (int i = 0; i < 12; i++) m_vis[i] <= m_pend[i];
                m_vis[12] <= m_ts;
                m_seq     <= m_seq + 8'd1;
                m_phase   <= 0;
            end
        end
    end

    initial begin : cmp
        logic [15:0] ea;
        forever begin
            @(negedge sysclk);
            ea = (m_phase >= 1 && m_phase <= 12) ? exp_addr(m_phase - 1) : 16'h0;
            chk("enc_raddr", 32'(bus.enc_raddr), 32'(ea));
            chk("snap_busy", 32'(bus.snap_busy), 32'(m_phase != 0));
            chk("snap_done", 32'(bus.snap_done), 32'(m_phase == 13));
            chk("snap_seq",  32'(bus.snap_seq),  32'(m_seq));
            chk("overrun",   32'(bus.overrun),   32'(m_ovr));
            chk("buf_rdata", bus.buf_rdata, m_rd);
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.buf_raddr = a;
        tick();
        d = bus.buf_rdata;
    endtask

    initial begin : drv
        logic [31:0] d, ts1, ts2;
        bus.snap_req    = 1'b0;
        bus.clr_overrun = 1'b0;
        bus.buf_raddr   = 4'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_seq",  32'(bus.snap_seq),  32'd0);
        chk("rst_busy", 32'(bus.snap_busy), 32'd0);
        rd(4'd15, d); chk("rst_stat", d, 32'd0);

        // Basic capture
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        chk("first_addr", 32'(bus.enc_raddr), 32'h0012);
        repeat (11) tick();
        chk("last_addr", 32'(bus.enc_raddr), 32'h0044);
        tick();
        chk("done_pulse", 32'(bus.snap_done), 32'd1);
        tick();
        rd(4'd4, d);  chk("ch2_period", d, 32'h11A5_0023);
        rd(4'd0, d);  chk("ch1_quad",   d, 32'h01A5_0012);
        rd(4'd15, d); chk("stat_seq1",  d, 32'h0100_0000);

        // Atomicity: word 0 flips only for reads from T+14 on
        bus.buf_raddr = 4'd0;
        tick();
        epoch = 8'h22;
        bus.snap_req = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            bus.snap_req = 1'b0;
            if (k == 14) chk("atom_old", bus.buf_rdata, 32'h01A5_0012);
            if (k == 15) chk("atom_new", bus.buf_rdata, 32'h00A5_0012);
        end

        // Overrun: request during RUN is dropped and sticks
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        repeat (4) tick();
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        repeat (10) tick();
        chk("ovr_set",      32'(bus.overrun),  32'd1);
        chk("ovr_seq_once", 32'(bus.snap_seq), 32'd3);
        bus.clr_overrun = 1'b1; tick(); bus.clr_overrun = 1'b0;
        chk("ovr_clr", 32'(bus.overrun), 32'd0);
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        repeat (2) tick();
        bus.snap_req = 1'b1; bus.clr_overrun = 1'b1; tick();
        bus.snap_req = 1'b0; bus.clr_overrun = 1'b0;
        chk("ovr_set_wins", 32'(bus.overrun), 32'd1);
        repeat (12) tick();
        bus.clr_overrun = 1'b1; tick(); bus.clr_overrun = 1'b0;

        // Sequence wrap: 256 snapshots at 14-cycle spacing
        repeat (256) begin
            bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
            repeat (13) tick();
        end
        chk("wrap_seq", 32'(bus.snap_seq), 32'd4);
        chk("wrap_ovr", 32'(bus.overrun),  32'd0);

        // Timestamp: two requests 1000 cycles apart
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        bus.buf_raddr = 4'd12;
        repeat (999) tick();
        ts1 = bus.buf_rdata;
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        repeat (20) tick();
        ts2 = bus.buf_rdata;
        chk("ts_delta", ts2 - ts1, 32'd1000);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.snap_req    = ($urandom_range(0, 9) == 0);
            bus.clr_overrun = ($urandom_range(0, 15) == 0);
            bus.buf_raddr   = 4'($urandom);
            if ($urandom_range(0, 49) == 0) epoch = 8'($urandom);
            tick();
        end
        bus.snap_req = 1'b0;
        bus.clr_overrun = 1'b0;
        repeat (20) tick();

        // Reset in the middle of a capture discards everything
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        for (int w = 0; w < 16; w++) begin
            rd(4'(w), d);
            chk($sformatf("rst_word%0d", w), d, 32'd0);
        end
        chk("rst2_seq",  32'(bus.snap_seq),  32'd0);
        chk("rst2_busy", 32'(bus.snap_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
